bit_serial_alu_seq: RTL

- Sequencer that drives a combinational 1-bit ALU slice and assembles a WIDTH-bit result over WIDTH cycles.
- The slice takes inputs a, b, carry-in c and a 2-bit aluctr, and returns result bit d and carry e.
- This block sits on the driving side of that interface. It supplies operand bits LSB-first and feeds e back as the next c for add.
- It gives the team a multi-bit ALU built from the existing 1-bit slice, with a start/done handshake toward the controller.

---
 rtl/bit_serial_alu_seq_if.sv | 24 ++
 rtl/bit_serial_alu_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/bit_serial_alu_seq_if.sv
// Controller-side handshake for the bit-serial ALU sequencer.
// The controller drives the request; the sequencer returns status and result.
interface bit_serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output start, op, opa, opb,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, op, opa, opb,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Drives an external combinational 1-bit ALU slice LSB-first and assembles a
// WIDTH-bit result over WIDTH cycles, chaining the slice carry for add.
module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bit_serial_alu_seq_if.slave  ctl,
    output logic                 slice_a,
    output logic                 slice_b,
    output logic                 slice_c,
    output logic [1:0]           slice_aluctr,
    input  logic                 slice_d,
    input  logic                 slice_e
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [1:0]    OP_ADD   = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             accept;
    logic             last_bit;

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a missing branch would otherwise infer a latch.
        state_next   = state;
        accept       = 1'b0;
        last_bit     = 1'b0;
        shift_next   = shift_q;
        slice_a      = 1'b0;
        slice_b      = 1'b0;
        slice_c      = 1'b0;
        slice_aluctr = op_q;
        case (state)
            IDLE: begin
                if (ctl.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                slice_a         = opa_q[cnt];
                slice_b         = opb_q[cnt];
                slice_c         = carry_q;
                shift_next[cnt] = slice_d;
                if (cnt == CNT_LAST) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is a flop vector, not a RAM, so it is reset with the rest of the datapath.
            cnt         <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            op_q        <= 2'b00;
            carry_q     <= 1'b0;
            shift_q     <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else if (accept) begin
            opa_q   <= ctl.opa;
            opb_q   <= ctl.opb;
            op_q    <= ctl.op;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else if (state == RUN) begin
            shift_q <= shift_next;
            // Carry only chains for add; logic ops leave it parked at zero.
            carry_q <= (op_q == OP_ADD) ? slice_e : 1'b0;
            if (last_bit) begin
                result_q    <= shift_next;
                carry_out_q <= (op_q == OP_ADD) ? slice_e : 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign ctl.busy      = (state == RUN);
    assign ctl.done      = (state == DONE);
    assign ctl.result    = result_q;
    assign ctl.carry_out = carry_out_q;

endmodule
